jtag_shift_sequencer: RTL and testbench
=======================================

// Module: jtag_shift_sequencer
// PURPOSE
//  Command-driven JTAG sequencer. It drives the same tck/tms/tdi/trst pins that
//  the VPI bridge drives in simulation, so it replaces host bit-banging with an
//  in-fabric engine. One command shifts 1..MAX_LEN bits with a programmable TCK
//  half-period. TDO bits are captured and returned as a single response word.
// PARAMETERS
//  MAX_LEN  32  max bits per command; cmd/rsp vector width
//  LEN_W    5   $clog2(MAX_LEN); cmd_len_i = bit count - 1
//  DIV_W    6   width of half-period counter (clk_i cycles per TCK half)
// PORTS
//  clk_i          in   1        system clock
//  rst_ni         in   1        synchronous reset, active-low
//  enable_i       in   1        0: no new commands accepted (in-flight ones finish)
//  half_period_i  in   DIV_W    TCK half-period in clk_i cycles; latched at accept; 0 -> 1
//  cmd_valid_i    in   1        command valid
//  cmd_ready_o    out  1        command ready
//  cmd_len_i      in   LEN_W    number of bits - 1
//  cmd_tms_i      in   MAX_LEN  TMS per bit, bit 0 first
//  cmd_tdi_i      in   MAX_LEN  TDI per bit, bit 0 first
//  cmd_trst_i     in   1        1: TAP reset pulse instead of shift
//  rsp_valid_o    out  1        response valid
//  rsp_ready_i    in   1        response accepted
//  rsp_tdo_o      out  MAX_LEN  captured TDO, bit i = bit i of cmd; bits >= N are 0
//  busy_o         out  1        state != IDLE
//  tck_o/tms_o/tdi_o  out 1     JTAG pins (registered)
//  trst_o         out  1        TAP reset, active-low (registered)
//  tdo_i          in   1        JTAG TDO from TAP
// BEHAVIOUR
//  Reset (rst_ni=0 at edge): state IDLE; tck_o=0, tms_o=1, tdi_o=0, trst_o=1,
//   rsp_valid_o=0, rsp_tdo_o=0, busy_o=0. Applies mid-command: the shift aborts
//   and the partial response is discarded.
//  cmd_ready_o = (state==IDLE) & enable_i; it is combinational from state.
//   Accept = cmd_valid_i & cmd_ready_o. Latch len, tms, tdi, trst, and H = max(half_period_i,1).
//  FSM: IDLE -> LO -> HI -> (LO | RSP); RSP -> IDLE.
//   Accept at edge k: LO, bit idx=0, tck_o=0, tms_o=tms[0], tdi_o=tdi[0], cnt=H-1.
//   LO/HI: cnt decrements each cycle. Leave the phase at the edge where cnt==0,
//    so each phase is exactly H cycles.
//   LO->HI: tck_o<=1; at the same edge rsp_tdo[idx]<=tdo_i (sample at TCK rise).
//   HI->LO (idx<len): tck_o<=0; idx++; tms_o/tdi_o <= bit idx+1, changed on TCK fall.
//   HI->RSP (idx==len): tck_o<=0; rsp_valid_o<=1; tms_o/tdi_o hold last bit.
//   Response latency: rsp_valid_o rises at edge k+2*H*N, where N=len+1.
//  RSP: hold rsp_valid_o and rsp_tdo_o stable until rsp_ready_i. At the handshake
//   edge, rsp_valid_o<=0 and go to IDLE. The next command is accepted no earlier
//   than the following cycle (no accept while RSP).
//  TRST command (cmd_trst_i=1): same timing as a shift of N bits, with these
//   differences: trst_o=0 from accept until the RSP transition; tms_o forced 1;
//   tdi_o=0; no capture (rsp_tdo_o=0). trst_o<=1 at the HI->RSP edge.
//  tdo_i is assumed stable at TCK rise; no internal synchronizer.
//  enable_i deassert mid-command has no effect on the command in flight.
//  Counter widths: idx LEN_W bits, never wraps (stops at len). cnt DIV_W bits.
// TESTING
//  1. Reset, then half_period_i=2, len=3, tms=4'b0000, tdi=4'b1010, TAP model with
//     tdo = delayed tdi -> 4 TCK pulses of 4 clk each; rsp at k+16; tdo bits match model.
//  2. half_period_i=0, len=0 -> treated as H=1; single TCK pulse; rsp_valid at k+2.
//  3. len=31, tms=32'h8000_0000 (Shift-DR exit on last bit) -> 32 pulses; tms_o=1 only
//     during bit 31; rsp_tdo_o holds 32 captured bits.
//  4. rsp_ready_i held 0 for 10 cycles with cmd_valid_i=1 pending -> rsp stable,
//     cmd_ready_o=0; accept happens the cycle after the rsp handshake.
//  5. cmd_trst_i=1, len=4, H=3 -> trst_o low 30 cycles, tms_o=1, 5 TCK pulses,
//     rsp_tdo_o=0.
//  6. rst_ni=0 during bit 2 of a len=7 shift -> next edge all outputs at reset values,
//     no rsp_valid_o. enable_i=0 -> cmd_ready_o=0.

Source files
------------

// File: rtl/jtag_shift_sequencer.sv
// rtl/jtag_shift_sequencer.sv - command-driven JTAG shift engine driving tck/tms/tdi/trst
// One command shifts 1..MAX_LEN bits with a programmable TCK half-period and returns captured TDO.
module jtag_shift_sequencer #(
    parameter int MAX_LEN = 32,
    parameter int LEN_W   = $clog2(MAX_LEN),
    parameter int DIV_W   = 6
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               enable_i,
    input  logic [DIV_W-1:0]   half_period_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [LEN_W-1:0]   cmd_len_i,
    input  logic [MAX_LEN-1:0] cmd_tms_i,
    input  logic [MAX_LEN-1:0] cmd_tdi_i,
    input  logic               cmd_trst_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [MAX_LEN-1:0] rsp_tdo_o,
    output logic               busy_o,
    output logic               tck_o,
    output logic               tms_o,
    output logic               tdi_o,
    output logic               trst_o,
    input  logic               tdo_i
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LO,
        ST_HI,
        ST_RSP
    } state_t;

    state_t             state_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   idx_q;
    logic [LEN_W-1:0]   idx_d;
    logic [MAX_LEN-1:0] tms_vec_q;
    logic [MAX_LEN-1:0] tdi_vec_q;
    logic [MAX_LEN-1:0] rsp_tdo_q;
    logic               trst_cmd_q;
    logic [DIV_W-1:0]   h_q;
    logic [DIV_W-1:0]   h_d;
    logic [DIV_W-1:0]   cnt_q;
    logic               tck_q;
    logic               tms_q;
    logic               tdi_q;
    logic               trst_q;
    logic               rsp_valid_q;
    logic               cmd_accept;

    assign cmd_ready_o = (state_q == ST_IDLE) && enable_i;
    assign cmd_accept  = cmd_valid_i && cmd_ready_o;

    always_comb begin
        h_d   = (half_period_i == '0) ? DIV_W'(1) : half_period_i;
        idx_d = idx_q + LEN_W'(1);
    end

    // A TAP-reset command reuses the shift timing with TMS forced high and TDI low,
    // so the vectors are overwritten at accept and the shift path stays uniform.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            idx_q       <= '0;
            tms_vec_q   <= '0;
            tdi_vec_q   <= '0;
            rsp_tdo_q   <= '0;
            trst_cmd_q  <= 1'b0;
            h_q         <= DIV_W'(1);
            cnt_q       <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            trst_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_accept) begin
                        len_q      <= cmd_len_i;
                        tms_vec_q  <= cmd_trst_i ? '1 : cmd_tms_i;
                        tdi_vec_q  <= cmd_trst_i ? '0 : cmd_tdi_i;
                        trst_cmd_q <= cmd_trst_i;
                        h_q        <= h_d;
                        cnt_q      <= h_d - DIV_W'(1);
                        idx_q      <= '0;
                        rsp_tdo_q  <= '0;
                        tck_q      <= 1'b0;
                        tms_q      <= cmd_trst_i | cmd_tms_i[0];
                        tdi_q      <= ~cmd_trst_i & cmd_tdi_i[0];
                        trst_q     <= ~cmd_trst_i;
                        state_q    <= ST_LO;
                    end
                end
                ST_LO: begin
                    if (cnt_q == '0) begin
                        tck_q <= 1'b1;
                        cnt_q <= h_q - DIV_W'(1);
                        if (!trst_cmd_q) begin
                            rsp_tdo_q[idx_q] <= tdo_i;
                        end
                        state_q <= ST_HI;
                    end else begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end
                end
                ST_HI: begin
                    if (cnt_q == '0) begin
                        tck_q <= 1'b0;
                        if (idx_q == len_q) begin
                            rsp_valid_q <= 1'b1;
                            trst_q      <= 1'b1;
                            state_q     <= ST_RSP;
                        end else begin
                            idx_q   <= idx_d;
                            tms_q   <= tms_vec_q[idx_d];
                            tdi_q   <= tdi_vec_q[idx_d];
                            cnt_q   <= h_q - DIV_W'(1);
                            state_q <= ST_LO;
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end
                end
                ST_RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_tdo_o   = rsp_tdo_q;
    assign tck_o       = tck_q;
    assign tms_o       = tms_q;
    assign tdi_o       = tdi_q;
    assign trst_o      = trst_q;

endmodule

// File: tb/tb_jtag_shift_sequencer.sv
// tb/tb_jtag_shift_sequencer.sv - self-checking bench for jtag_shift_sequencer
// Elapsed-time reference model plus directed literal checks and randomized commands.
module tb_jtag_shift_sequencer;

    localparam int ML = 32;
    localparam int LW = 5;
    localparam int DW = 6;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          enable_i = 1'b0;
    logic [DW-1:0] half_period_i = '0;
    logic          cmd_valid_i = 1'b0;
    logic          cmd_ready_o;
    logic [LW-1:0] cmd_len_i = '0;
    logic [ML-1:0] cmd_tms_i = '0;
    logic [ML-1:0] cmd_tdi_i = '0;
    logic          cmd_trst_i = 1'b0;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [ML-1:0] rsp_tdo_o;
    logic          busy_o;
    logic          tck_o, tms_o, tdi_o, trst_o;
    logic          tdo_i = 1'b0;

    jtag_shift_sequencer #(.MAX_LEN(ML), .LEN_W(LW), .DIV_W(DW)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .enable_i(enable_i), .half_period_i(half_period_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_len_i(cmd_len_i),
        .cmd_tms_i(cmd_tms_i), .cmd_tdi_i(cmd_tdi_i), .cmd_trst_i(cmd_trst_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_tdo_o(rsp_tdo_o),
        .busy_o(busy_o), .tck_o(tck_o), .tms_o(tms_o), .tdi_o(tdi_o), .trst_o(trst_o),
        .tdo_i(tdo_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: after an accept, everything follows from t = edges since accept.
    int          m_mode = 0;
    int          m_t, m_h, m_n;
    logic        m_trst;
    logic [31:0] m_tms, m_tdi;
    logic [31:0] m_tdo = '0;
    logic        m_hold_tms = 1'b1;
    logic        m_hold_tdi = 1'b0;
    bit          started = 0;

    always @(posedge clk) begin
        if (!rst_ni) begin
            started = 1;
            m_mode = 0;
            m_tdo = '0;
            m_hold_tms = 1'b1;
            m_hold_tdi = 1'b0;
        end else if (started) begin
            case (m_mode)
                0: if (cmd_valid_i && enable_i) begin
                    m_h = (half_period_i == 0) ? 1 : int'(half_period_i);
                    m_n = int'(cmd_len_i) + 1;
                    m_trst = cmd_trst_i;
                    m_tms = cmd_tms_i;
                    m_tdi = cmd_tdi_i;
                    m_tdo = '0;
                    m_t = 0;
                    m_mode = 1;
                end
                1: begin
                    m_t++;
                    if (!m_trst && (m_t % (2 * m_h)) == m_h) m_tdo[m_t / (2 * m_h)] = tdo_i;
                    if (m_t == 2 * m_h * m_n) begin
                        m_mode = 2;
                        m_hold_tms = m_trst ? 1'b1 : m_tms[m_n - 1];
                        m_hold_tdi = m_trst ? 1'b0 : m_tdi[m_n - 1];
                    end
                end
                default: if (rsp_ready_i) m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin : cmp
        int   j;
        logic e_tck, e_tms, e_tdi, e_trst, e_busy, e_ready, e_rv;
        if (started) begin
            e_tck = 0; e_tms = m_hold_tms; e_tdi = m_hold_tdi; e_trst = 1;
            e_busy = 1; e_ready = 0; e_rv = 0;
            if (m_mode == 0) begin
                e_busy = 0;
                e_ready = enable_i;
            end else if (m_mode == 1) begin
                j = m_t / (2 * m_h);
                e_tck = (m_t % (2 * m_h)) >= m_h;
                e_tms = m_trst ? 1'b1 : m_tms[j];
                e_tdi = m_trst ? 1'b0 : m_tdi[j];
                e_trst = !m_trst;
            end else begin
                e_rv = 1;
            end
            chk("tck", 32'(tck_o), 32'(e_tck));
            chk("tms", 32'(tms_o), 32'(e_tms));
            chk("tdi", 32'(tdi_o), 32'(e_tdi));
            chk("trst", 32'(trst_o), 32'(e_trst));
            chk("busy", 32'(busy_o), 32'(e_busy));
            chk("cmd_ready", 32'(cmd_ready_o), 32'(e_ready));
            chk("rsp_valid", 32'(rsp_valid_o), 32'(e_rv));
            chk("rsp_tdo", rsp_tdo_o, m_tdo);
        end
    end

    // TAP stand-in: either TDO = TDI delayed by one TCK, or random per clock.
    logic tap_reg = 1'b0;
    logic prev_tck = 1'b0;
    bit   tap_delay = 1;
    int   rr_mode = 0;
    always @(posedge clk) begin
        #1;
        if (tck_o && !prev_tck) tap_reg = tdi_o;
        prev_tck = tck_o;
        tdo_i = tap_delay ? tap_reg : 1'($urandom);
        case (rr_mode)
            0: rsp_ready_i = 1'b1;
            1: rsp_ready_i = ($urandom_range(0, 3) == 0);
            default: rsp_ready_i = 1'b0;
        endcase
    end

    int   tck_rises = 0, trst_low = 0, tms_hi = 0;
    int   acc_cyc = 0, hs_cyc = 0, rv_cyc = 0;
    logic last_tck = 1'b0;
    always @(negedge clk) begin
        if (tck_o && !last_tck) tck_rises++;
        last_tck = tck_o;
        if (!trst_o) trst_low++;
        if (tms_o && busy_o && !rsp_valid_o) tms_hi++;
        if (cmd_valid_i && cmd_ready_o) acc_cyc = cyc + 1;
        if (rsp_valid_o && rsp_ready_i) hs_cyc = cyc + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int len, input int hp, input logic [31:0] tms,
                        input logic [31:0] tdi, input bit trst);
        bit ok = 0;
        cmd_len_i = LW'(len); half_period_i = DW'(hp);
        cmd_tms_i = tms; cmd_tdi_i = tdi; cmd_trst_i = trst; cmd_valid_i = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (cmd_ready_o) begin ok = 1; break; end
        end
        if (!ok) chk("accept_timeout", 32'(0), 32'(1));
        tick();
        cmd_valid_i = 1'b0;
        cmd_tms_i = $urandom; cmd_tdi_i = $urandom; cmd_trst_i = 1'($urandom);
        cmd_len_i = LW'($urandom); half_period_i = DW'($urandom);
    endtask

    task automatic wait_rsp();
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rsp_valid_o) begin ok = 1; break; end
        end
        if (!ok) chk("rsp_timeout", 32'(0), 32'(1));
        rv_cyc = cyc;
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy_o) begin ok = 1; break; end
        end
        if (!ok) chk("idle_timeout", 32'(0), 32'(1));
        tick();
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          r0, l0, m0;
        logic [31:0] v, snap;
        logic        tap0;
        repeat (3) tick();
        chk("rst_tck", 32'(tck_o), 32'(0));
        chk("rst_tms", 32'(tms_o), 32'(1));
        chk("rst_trst", 32'(trst_o), 32'(1));
        chk("rst_busy", 32'(busy_o), 32'(0));
        chk("rst_rsp_tdo", rsp_tdo_o, 32'h0);
        rst_ni = 1'b1; enable_i = 1'b1; rr_mode = 0;
        tick();

        // 1: H=2, 4 bits, TDO = TDI delayed by one TCK
        tap_delay = 1; tap_reg = 1'b0;
        r0 = tck_rises;
        send(3, 2, 32'h0, 32'hA, 0);
        wait_rsp();
        chk("t1_latency", 32'(rv_cyc - acc_cyc), 32'd16);
        chk("t1_tdo", rsp_tdo_o, 32'h4);
        chk("t1_pulses", 32'(tck_rises - r0), 32'd4);
        wait_idle();

        // 2: half_period 0 behaves as 1, single bit
        tap_delay = 0;
        r0 = tck_rises;
        send(0, 0, $urandom, $urandom, 0);
        wait_rsp();
        chk("t2_latency", 32'(rv_cyc - acc_cyc), 32'd2);
        chk("t2_pulses", 32'(tck_rises - r0), 32'd1);
        wait_idle();

        // 3: full 32-bit shift leaving Shift-DR on the last bit
        tap_delay = 1; tap0 = tap_reg; v = $urandom;
        r0 = tck_rises; m0 = tms_hi;
        send(31, 1, 32'h8000_0000, v, 0);
        wait_rsp();
        chk("t3_pulses", 32'(tck_rises - r0), 32'd32);
        chk("t3_tms_hi", 32'(tms_hi - m0), 32'd2);
        chk("t3_tdo", rsp_tdo_o, {v[30:0], tap0});
        wait_idle();

        // 4: response back-pressure with a command pending
        rr_mode = 2;
        send(2, 1, $urandom, $urandom, 0);
        wait_rsp();
        snap = rsp_tdo_o;
        tick();
        cmd_len_i = 5'd1; half_period_i = 6'd1; cmd_tms_i = $urandom; cmd_tdi_i = $urandom;
        cmd_trst_i = 1'b0; cmd_valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_ready_low", 32'(cmd_ready_o), 32'(0));
            chk("t4_rsp_hold", rsp_tdo_o, snap);
        end
        rr_mode = 0;
        send(1, 1, cmd_tms_i, cmd_tdi_i, 0);
        chk("t4_gap", 32'(acc_cyc - hs_cyc), 32'd1);
        wait_rsp();
        wait_idle();

        // 5: TAP reset pulse, 5 bits at H=3
        r0 = tck_rises; l0 = trst_low; m0 = tms_hi;
        send(4, 3, 32'h0, $urandom, 1);
        wait_rsp();
        chk("t5_tdo", rsp_tdo_o, 32'h0);
        wait_idle();
        chk("t5_trst_low", 32'(trst_low - l0), 32'd30);
        chk("t5_tms_hi", 32'(tms_hi - m0), 32'd30);
        chk("t5_pulses", 32'(tck_rises - r0), 32'd5);

        // 6: reset during bit 2 of an 8-bit shift, then enable low
        send(7, 2, $urandom, 32'hFFFF_FFFF, 0);
        repeat (9) tick();
        rst_ni = 1'b0;
        tick();
        chk("t6_tck", 32'(tck_o), 32'(0));
        chk("t6_tms", 32'(tms_o), 32'(1));
        chk("t6_tdi", 32'(tdi_o), 32'(0));
        chk("t6_trst", 32'(trst_o), 32'(1));
        chk("t6_rsp_valid", 32'(rsp_valid_o), 32'(0));
        chk("t6_busy", 32'(busy_o), 32'(0));
        chk("t6_rsp_tdo", rsp_tdo_o, 32'h0);
        rst_ni = 1'b1; enable_i = 1'b0; cmd_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_ready_dis", 32'(cmd_ready_o), 32'(0));
        end
        tick();
        cmd_valid_i = 1'b0; enable_i = 1'b1;
        tick();

        // randomized commands with random back-pressure and enable toggling
        rr_mode = 1;
        for (int n = 0; n < 40; n++) begin
            int len;
            tap_delay = 1'($urandom);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 6);
            if ($urandom_range(0, 4) == 0) begin
                enable_i = 1'b0; cmd_valid_i = 1'b1;
                repeat ($urandom_range(1, 4)) tick();
                enable_i = 1'b1;
            end
            send(len, $urandom_range(0, 4), $urandom, $urandom, ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 2) == 0) enable_i = 1'b0;
            wait_rsp();
            enable_i = 1'b1;
            wait_idle();
        end

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
